// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode constants, TX/RX FSM state
// encodings and a parity helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Words narrower than 8 bits are zero-extended; the extra zeros do not
    // change the XOR, so one helper covers all legal data widths.
    function automatic logic parity_of(input logic [7:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_fifo_drive_if.sv
// User-side word interface of uart_fifo_drive.
//   i_user_tx_data / i_user_tx_valid / o_user_tx_ready : TX word handshake
//   o_user_rx_data / o_user_rx_valid / i_user_rx_ready : RX word handshake (FWFT)
// slave modport is the UART side, master modport is the user side.
interface uart_fifo_drive_if #(
    parameter int P_UART_DATA_WIDTH = 8
);
    logic [P_UART_DATA_WIDTH-1:0] i_user_tx_data;
    logic                         i_user_tx_valid;
    logic                         o_user_tx_ready;
    logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data;
    logic                         o_user_rx_valid;
    logic                         i_user_rx_ready;

    modport slave (
        input  i_user_tx_data,
        input  i_user_tx_valid,
        output o_user_tx_ready,
        output o_user_rx_data,
        output o_user_rx_valid,
        input  i_user_rx_ready
    );

    modport master (
        output i_user_tx_data,
        output i_user_tx_valid,
        input  o_user_tx_ready,
        input  o_user_rx_data,
        input  o_user_rx_valid,
        output i_user_rx_ready
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst_n     : clock, asynchronous active-low reset
//   push/push_data : write request and word
//   pop/pop_data   : read request; pop_data shows the head word (0 when empty)
//   full/empty     : occupancy flags
// A push while full is accepted when a pop frees the slot in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra MSB on the pointers separates full from empty when indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_fifo_drive.sv
// UART transceiver with TX and RX word FIFOs.
//   i_clk, i_rst_n    : clock, asynchronous active-low reset
//   i_uart_rx         : serial input (asynchronous, synchronised internally)
//   o_uart_tx         : serial output, idles high
//   user              : TX/RX word handshakes (uart_fifo_drive_if.slave)
//   o_rx_parity_err, o_rx_frame_err, o_rx_overrun : one-cycle error pulses
//   o_tx_busy         : frame on the line or TX FIFO not empty
module uart_fifo_drive import uart_pkg::*; #(
    parameter int P_SYSTEM_CLK      = 50_000_000,
    parameter int P_UART_BUADRATE   = 115200,
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_UART_STOP_WIDTH = 1,
    parameter int P_UART_CHECK      = 0,
    parameter int P_FIFO_DEPTH      = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_uart_rx,
    output logic               o_uart_tx,
    uart_fifo_drive_if.slave   user,
    output logic               o_rx_parity_err,
    output logic               o_rx_frame_err,
    output logic               o_rx_overrun,
    output logic               o_tx_busy
);
    localparam int W   = P_UART_DATA_WIDTH;
    localparam int DIV = P_SYSTEM_CLK / P_UART_BUADRATE;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [2:0]    DATA_LAST = 3'(W - 1);
    localparam logic [2:0]    STOP_LAST = 3'(P_UART_STOP_WIDTH - 1);

    // ---------------- TX path ----------------
    logic         tx_push, tx_pop, tx_full, tx_empty;
    logic [W-1:0] tx_fifo_data;
    tx_state_t    tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]   tx_bit, tx_bit_n;
    logic [W-1:0] tx_shift, tx_shift_n;
    logic         tx_par, tx_par_n;
    logic         tx_line, tx_line_n;
    logic         tx_bit_end;

    assign user.o_user_tx_ready = i_rst_n && !tx_full;
    assign tx_push = user.i_user_tx_valid && user.o_user_tx_ready;

    uart_sync_fifo #(.WIDTH(W), .DEPTH(P_FIFO_DEPTH)) u_tx_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (tx_push),
        .push_data (user.i_user_tx_data),
        .pop       (tx_pop),
        .pop_data  (tx_fifo_data),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    assign tx_bit_end = (tx_cnt == BIT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_par   <= tx_par_n;
            tx_line  <= tx_line_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 1'b1;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_par_n   = tx_par;
        tx_pop     = 1'b0;
        tx_line_n  = 1'b1;
        unique case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_fifo_data;
                    tx_par_n   = parity_of(8'(tx_fifo_data), P_UART_CHECK);
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_n   = '0;
                    tx_shift_n = tx_shift >> 1;
                    if (tx_bit == DATA_LAST) begin
                        tx_bit_n   = '0;
                        tx_state_n = (P_UART_CHECK != PARITY_NONE) ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_bit_n = tx_bit + 1'b1;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    tx_cnt_n = '0;
                    if (tx_bit == STOP_LAST) begin
                        tx_bit_n = '0;
                        // Chain straight into the next start bit when words wait.
                        if (!tx_empty) begin
                            tx_pop     = 1'b1;
                            tx_shift_n = tx_fifo_data;
                            tx_par_n   = parity_of(8'(tx_fifo_data), P_UART_CHECK);
                            tx_state_n = TX_START;
                        end else begin
                            tx_state_n = TX_IDLE;
                        end
                    end else begin
                        tx_bit_n = tx_bit + 1'b1;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
        // Line level follows the state being entered, so the output is registered.
        unique case (tx_state_n)
            TX_START:  tx_line_n = 1'b0;
            TX_DATA:   tx_line_n = tx_shift_n[0];
            TX_PARITY: tx_line_n = tx_par_n;
            default:   tx_line_n = 1'b1;
        endcase
    end

    assign o_uart_tx = tx_line;
    assign o_tx_busy = (tx_state != TX_IDLE) || !tx_empty;

    // ---------------- RX path ----------------
    logic          rx_meta, rx_sync, rx_prev, rx_fall;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [W-1:0]  rx_fifo_data;
    rx_state_t     rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [W-1:0]  rx_shift, rx_shift_n;
    logic          rx_par, rx_par_n;
    logic          perr, perr_n, ferr, ferr_n, ovr, ovr_n;
    logic          rx_bit_end;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall    = rx_prev && !rx_sync;
    assign rx_bit_end = (rx_cnt == BIT_LAST);
    assign rx_pop     = user.o_user_rx_valid && user.i_user_rx_ready;

    uart_sync_fifo #(.WIDTH(W), .DEPTH(P_FIFO_DEPTH)) u_rx_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (rx_pop),
        .pop_data  (rx_fifo_data),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    assign user.o_user_rx_valid = !rx_empty;
    assign user.o_user_rx_data  = rx_fifo_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_par   <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            rx_par   <= rx_par_n;
            perr     <= perr_n;
            ferr     <= ferr_n;
            ovr      <= ovr_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 1'b1;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_par_n   = rx_par;
        rx_push    = 1'b0;
        perr_n     = 1'b0;
        ferr_n     = 1'b0;
        ovr_n      = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (rx_fall) rx_state_n = RX_START;
            end
            RX_START: begin
                // Half a bit in: line back high means a glitch, not a start bit.
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n = '0;
                    if (rx_sync) begin
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_bit_n   = '0;
                        rx_state_n = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_sync, rx_shift[W-1:1]};
                    if (rx_bit == DATA_LAST) begin
                        rx_bit_n   = '0;
                        rx_state_n = (P_UART_CHECK != PARITY_NONE) ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_n = rx_bit + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_bit_end) begin
                    rx_cnt_n   = '0;
                    rx_par_n   = rx_sync;
                    rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_IDLE;
                    ferr_n = !rx_sync;
                    perr_n = (P_UART_CHECK != PARITY_NONE) &&
                             (rx_par != parity_of(8'(rx_shift), P_UART_CHECK));
                    if (!ferr_n && !perr_n) begin
                        if (rx_full && !rx_pop) ovr_n = 1'b1;
                        else                    rx_push = 1'b1;
                    end
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    assign o_rx_parity_err = perr;
    assign o_rx_frame_err  = ferr;
    assign o_rx_overrun    = ovr;

endmodule

// File: tb/tb_uart_fifo_drive.sv
module tb_uart_fifo_drive;
    localparam int DIV  = 16;   // 1.6 MHz / 100 kbaud
    localparam int DIV0 = 434;  // defaults: 50 MHz / 115200

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    // Main DUT: odd parity, fast bit rate
    logic rx_line = 1'b1;
    logic tx_line, perr, ferr, ovr, busy;
    uart_fifo_drive_if #(.P_UART_DATA_WIDTH(8)) uif ();
    uart_fifo_drive #(
        .P_SYSTEM_CLK(1_600_000), .P_UART_BUADRATE(100_000),
        .P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1),
        .P_UART_CHECK(1), .P_FIFO_DEPTH(16)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx_line), .o_uart_tx(tx_line),
        .user(uif), .o_rx_parity_err(perr), .o_rx_frame_err(ferr),
        .o_rx_overrun(ovr), .o_tx_busy(busy)
    );

    // Second DUT with all default parameters
    logic rx0 = 1'b1;
    logic tx0, perr0, ferr0, ovr0, busy0;
    uart_fifo_drive_if #(.P_UART_DATA_WIDTH(8)) if0 ();
    uart_fifo_drive dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx0), .o_uart_tx(tx0),
        .user(if0), .o_rx_parity_err(perr0), .o_rx_frame_err(ferr0),
        .o_rx_overrun(ovr0), .o_tx_busy(busy0)
    );

    int n_perr = 0, n_ferr = 0, n_ovr = 0;
    always @(negedge clk) begin
        if (perr) n_perr++;
        if (ferr) n_ferr++;
        if (ovr)  n_ovr++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference: odd parity bit makes the total count of ones odd
    function automatic logic odd_par(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        return (ones % 2 == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rx(input logic [7:0] d, input logic par, input logic stp);
        rx_line = 1'b0;
        repeat (DIV) tick();
        for (int i = 0; i < 8; i++) begin
            rx_line = d[i];
            repeat (DIV) tick();
        end
        rx_line = par;
        repeat (DIV) tick();
        rx_line = stp;
        repeat (DIV) tick();
        rx_line = 1'b1;
    endtask

    // Waits for a start bit on tx_line and samples each bit at its centre.
    task automatic decode_tx(input int lim, output logic [7:0] d, output logic par,
                             output logic stp, output int t_start, output logic ok);
        int n = 0;
        ok = 1'b0; d = '0; par = 1'b0; stp = 1'b0; t_start = 0;
        while (tx_line !== 1'b0 && n < lim) begin tick(); n++; end
        if (tx_line === 1'b0) begin
            ok = 1'b1;
            t_start = cyc;
            repeat (DIV / 2) tick();
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) tick();
                d[i] = tx_line;
            end
            repeat (DIV) tick();
            par = tx_line;
            repeat (DIV) tick();
            stp = tx_line;
        end
    endtask

    task automatic test_reset();
        uif.i_user_tx_data = '0; uif.i_user_tx_valid = 1'b0; uif.i_user_rx_ready = 1'b0;
        if0.i_user_tx_data = '0; if0.i_user_tx_valid = 1'b0; if0.i_user_rx_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx_line); end
        checks++; if (uif.o_user_tx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", uif.o_user_tx_ready); end
        checks++; if (uif.o_user_rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", uif.o_user_rx_valid); end
        checks++; if (uif.o_user_rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", uif.o_user_rx_data); end
        checks++; if ({perr, ferr, ovr, busy} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {perr, ferr, ovr, busy}); end
        rst_n = 1'b1;
        tick();
        checks++; if (uif.o_user_tx_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", uif.o_user_tx_ready); end
    endtask

    task automatic test_default_tx();
        logic [7:0] d;
        logic       exp_bits [10];
        int         t;
        d = 8'hA5;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i + 1] = d[i];
        exp_bits[9] = 1'b1;
        if0.i_user_tx_data = d;
        if0.i_user_tx_valid = 1'b1;
        tick();
        if0.i_user_tx_valid = 1'b0;
        t = 0;
        while (tx0 !== 1'b0 && t < 10) begin tick(); t++; end
        checks++; if (t > 2) begin errors++; $display("FAIL default_start_latency: got %0d cycles want <=2", t); end
        for (int k = 0; k < 10; k++) begin
            checks++; if (tx0 !== exp_bits[k]) begin errors++; $display("FAIL default_bit%0d_first: got %b want %b", k, tx0, exp_bits[k]); end
            repeat (DIV0 - 1) tick();
            checks++; if (tx0 !== exp_bits[k]) begin errors++; $display("FAIL default_bit%0d_last: got %b want %b", k, tx0, exp_bits[k]); end
            tick();
        end
        checks++; if (tx0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL default_idle_after: got tx=%b busy=%b want tx=1 busy=0", tx0, busy0); end
    endtask

    task automatic test_rx_parity();
        int p0, f0;
        p0 = n_perr; f0 = n_ferr;
        drive_rx(8'h3C, 1'b1, 1'b1);
        repeat (4) tick();
        checks++; if (uif.o_user_rx_valid !== 1'b1 || uif.o_user_rx_data !== 8'h3C) begin errors++; $display("FAIL rx_good: got valid=%b data=%h want valid=1 data=3c", uif.o_user_rx_valid, uif.o_user_rx_data); end
        checks++; if (n_perr - p0 !== 0) begin errors++; $display("FAIL rx_good_perr: got %0d pulses want 0", n_perr - p0); end
        uif.i_user_rx_ready = 1'b1;
        tick();
        uif.i_user_rx_ready = 1'b0;
        checks++; if (uif.o_user_rx_valid !== 1'b0) begin errors++; $display("FAIL rx_pop_empty: got valid=%b want 0", uif.o_user_rx_valid); end
        drive_rx(8'h3C, 1'b0, 1'b1);
        repeat (4) tick();
        checks++; if (n_perr - p0 !== 1) begin errors++; $display("FAIL rx_bad_parity: got %0d pulses want 1", n_perr - p0); end
        checks++; if (uif.o_user_rx_valid !== 1'b0 || n_ferr - f0 !== 0) begin errors++; $display("FAIL rx_bad_parity_side: got valid=%b ferr=%0d want 0/0", uif.o_user_rx_valid, n_ferr - f0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [17];
        logic [7:0] d;
        logic       par, stp, ok, acc;
        int         ts, t_prev, n;
        for (int i = 0; i < 17; i++) words[i] = 8'($urandom_range(0, 255));
        fork
            begin
                for (int i = 0; i < 17; i++) begin
                    uif.i_user_tx_data = words[i];
                    uif.i_user_tx_valid = 1'b1;
                    n = 0;
                    do begin
                        acc = uif.o_user_tx_ready;
                        tick();
                        n++;
                    end while (!acc && n < 4000);
                end
                uif.i_user_tx_valid = 1'b0;
                checks++; if (uif.o_user_tx_ready !== 1'b0) begin errors++; $display("FAIL burst_ready_full: got %b want 0", uif.o_user_tx_ready); end
            end
            begin
                t_prev = 0;
                for (int i = 0; i < 17; i++) begin
                    decode_tx(4000, d, par, stp, ts, ok);
                    checks++; if (!ok || d !== words[i]) begin errors++; $display("FAIL burst_word%0d: got %h ok=%b want %h", i, d, ok, words[i]); end
                    checks++; if (par !== odd_par(words[i]) || stp !== 1'b1) begin errors++; $display("FAIL burst_frame%0d: got par=%b stop=%b want par=%b stop=1", i, par, stp, odd_par(words[i])); end
                    if (i > 0) begin
                        checks++; if (ts - t_prev !== 11 * DIV) begin errors++; $display("FAIL burst_gap%0d: got %0d cycles want %0d", i, ts - t_prev, 11 * DIV); end
                    end
                    t_prev = ts;
                end
            end
        join
        repeat (DIV) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_rx_overrun();
        logic [7:0] words [17];
        int o0, p0, f0;
        o0 = n_ovr; p0 = n_perr; f0 = n_ferr;
        uif.i_user_rx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            words[i] = 8'($urandom_range(0, 255));
            drive_rx(words[i], odd_par(words[i]), 1'b1);
        end
        repeat (4) tick();
        checks++; if (n_ovr - o0 !== 1) begin errors++; $display("FAIL overrun_pulses: got %0d want 1", n_ovr - o0); end
        checks++; if (n_perr - p0 !== 0 || n_ferr - f0 !== 0) begin errors++; $display("FAIL overrun_errs: got perr=%0d ferr=%0d want 0/0", n_perr - p0, n_ferr - f0); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (uif.o_user_rx_valid !== 1'b1 || uif.o_user_rx_data !== words[i]) begin errors++; $display("FAIL overrun_read%0d: got valid=%b data=%h want 1/%h", i, uif.o_user_rx_valid, uif.o_user_rx_data, words[i]); end
            uif.i_user_rx_ready = 1'b1;
            tick();
            uif.i_user_rx_ready = 1'b0;
        end
        checks++; if (uif.o_user_rx_valid !== 1'b0) begin errors++; $display("FAIL overrun_drained: got valid=%b want 0", uif.o_user_rx_valid); end
    endtask

    task automatic test_rx_glitch_frame();
        logic [7:0] d;
        int p0, f0;
        p0 = n_perr; f0 = n_ferr;
        rx_line = 1'b0;
        repeat (DIV / 4) tick();
        rx_line = 1'b1;
        repeat (3 * DIV) tick();
        checks++; if (uif.o_user_rx_valid !== 1'b0 || n_perr - p0 !== 0 || n_ferr - f0 !== 0) begin errors++; $display("FAIL glitch: got valid=%b perr=%0d ferr=%0d want 0/0/0", uif.o_user_rx_valid, n_perr - p0, n_ferr - f0); end
        d = 8'($urandom_range(0, 255));
        drive_rx(d, odd_par(d), 1'b0);
        repeat (4) tick();
        checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL frame_err: got %0d pulses want 1", n_ferr - f0); end
        checks++; if (uif.o_user_rx_valid !== 1'b0 || n_perr - p0 !== 0) begin errors++; $display("FAIL frame_err_side: got valid=%b perr=%0d want 0/0", uif.o_user_rx_valid, n_perr - p0); end
        repeat (DIV) tick();
    endtask

    task automatic test_reset_mid_tx();
        logic [7:0] d;
        logic       par, stp, ok;
        int         ts, n, lows;
        d = 8'($urandom_range(0, 255));
        drive_rx(d, odd_par(d), 1'b1);
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            uif.i_user_tx_data = 8'($urandom_range(0, 255));
            uif.i_user_tx_valid = 1'b1;
            tick();
        end
        uif.i_user_tx_valid = 1'b0;
        n = 0;
        while (tx_line !== 1'b0 && n < 100) begin tick(); n++; end
        repeat (3 * DIV) tick();
        #3 rst_n = 1'b0;
        #1;
        checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b want 1", tx_line); end
        checks++; if (busy !== 1'b0 || uif.o_user_tx_ready !== 1'b0) begin errors++; $display("FAIL midreset_busy_ready: got %b/%b want 0/0", busy, uif.o_user_tx_ready); end
        checks++; if (uif.o_user_rx_valid !== 1'b0 || uif.o_user_rx_data !== 8'h00) begin errors++; $display("FAIL midreset_rx: got valid=%b data=%h want 0/00", uif.o_user_rx_valid, uif.o_user_rx_data); end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        lows = 0;
        for (int i = 0; i < 3 * DIV; i++) begin
            if (tx_line !== 1'b1 || busy !== 1'b0) lows++;
            tick();
        end
        checks++; if (lows !== 0) begin errors++; $display("FAIL postreset_quiet: got %0d active cycles want 0", lows); end
        d = 8'($urandom_range(0, 255));
        uif.i_user_tx_data = d;
        uif.i_user_tx_valid = 1'b1;
        tick();
        uif.i_user_tx_valid = 1'b0;
        decode_tx(100, d, par, stp, ts, ok);
        checks++; if (!ok || d !== uif.i_user_tx_data) begin errors++; $display("FAIL postreset_word: got %h ok=%b want %h", d, ok, uif.i_user_tx_data); end
        checks++; if (par !== odd_par(uif.i_user_tx_data) || stp !== 1'b1) begin errors++; $display("FAIL postreset_frame: got par=%b stop=%b want %b/1", par, stp, odd_par(uif.i_user_tx_data)); end
    endtask

    initial begin
        test_reset();
        test_default_tx();
        test_rx_parity();
        test_back_to_back();
        test_rx_overrun();
        test_rx_glitch_frame();
        test_reset_mid_tx();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_fifo_drive.md
UART_FIFO_DRIVE -- requirements
Module: uart_fifo_drive

Interface
REQ-001 SHALL have parameter P_SYSTEM_CLK, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter P_UART_BUADRATE, default 115200, line bit rate.
REQ-003 SHALL have parameter P_UART_DATA_WIDTH, default 8, data bits per frame, legal 5..8.
REQ-004 SHALL have parameter P_UART_STOP_WIDTH, default 1, stop bits, legal 1 or 2.
REQ-005 SHALL have parameter P_UART_CHECK, default 0, parity mode: NONE=0, ODD=1, EVEN=2.
REQ-006 SHALL have parameter P_FIFO_DEPTH, default 16, entries per TX and RX FIFO, power of two, 2..256.
REQ-007 SHALL have ports: i_clk  in  1  system clock, one clock domain, all logic on rising edge.
REQ-008 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-009 i_uart_rx  in  1  serial RX line, asynchronous to i_clk.
REQ-010 o_uart_tx  out  1  serial TX line.
REQ-011 i_user_tx_data  in  P_UART_DATA_WIDTH  TX word; i_user_tx_valid  in  1; o_user_tx_ready  out  1.
REQ-012 o_user_rx_data  out  P_UART_DATA_WIDTH  RX word; o_user_rx_valid  out  1; i_user_rx_ready  in  1.
REQ-013 o_rx_parity_err, o_rx_frame_err, o_rx_overrun  out  1 each  single-cycle error pulses.
REQ-014 o_tx_busy  out  1  high while a frame is on the line or TX FIFO is non-empty.

Function
REQ-015 Bit period SHALL be DIV = P_SYSTEM_CLK / P_UART_BUADRATE cycles (integer truncation); counter width SHALL be $clog2(DIV).
REQ-016 Frame SHALL be: start(0), data LSB first, parity bit if P_UART_CHECK!=0, P_UART_STOP_WIDTH stop bits(1).
REQ-017 Parity: ODD = XOR of data inverted; EVEN = XOR of data.
REQ-018 TX handshake: word accepted in cycle where i_user_tx_valid && o_user_tx_ready; o_user_tx_ready = TX FIFO not full.
REQ-019 TX FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START when TX FIFO non-empty (pop same cycle); each state lasts DIV cycles per bit; PARITY skipped when P_UART_CHECK=0; STOP->START directly if FIFO non-empty, else IDLE (no idle gap between back-to-back frames).
REQ-020 Start bit SHALL appear on o_uart_tx no later than 2 cycles after the accepting handshake when TX is idle.
REQ-021 i_uart_rx SHALL pass a 2-flop synchroniser before use.
REQ-022 RX FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START on synchronised falling edge; at DIV/2 into START, line high -> back to IDLE (glitch reject, no error); data/parity/stop sampled at each bit centre.
REQ-023 Stop sampled 0 -> o_rx_frame_err pulse, word discarded; parity mismatch -> o_rx_parity_err pulse, word discarded; both may pulse together.
REQ-024 Only the first stop bit SHALL be checked on RX; RX returns to IDLE at centre of that stop bit.
REQ-025 Good word with RX FIFO full -> word dropped, o_rx_overrun pulse, FIFO contents unchanged.
REQ-026 RX output SHALL be first-word-fall-through: o_user_rx_valid = RX FIFO non-empty; pop on o_user_rx_valid && i_user_rx_ready.
REQ-027 Simultaneous push and pop on a full or empty FIFO SHALL both take effect when legal (pop on full frees slot, push on empty is not visible until next cycle).
REQ-028 FIFO pointers SHALL wrap modulo P_FIFO_DEPTH with an extra bit for full/empty discrimination.

Reset
REQ-029 On i_rst_n low: o_uart_tx=1, o_user_tx_ready=0 during reset then 1, o_user_rx_valid=0, o_user_rx_data=0, all error pulses 0, o_tx_busy=0, both FSMs IDLE, FIFOs empty, synchroniser flops=1.
REQ-030 Reset mid-frame SHALL abort immediately; a partial TX frame is truncated with line forced high.

Structure
REQ-031 Shared package uart_pkg SHALL hold parity mode constants (NONE/ODD/EVEN) and FSM state encodings for TX and RX.
REQ-032 One sub-module uart_sync_fifo (parameters width, depth; FWFT) SHALL be instantiated twice (TX, RX).

Verification
REQ-033 Defaults, send 8'hA5 -> o_uart_tx shows 0,1,0,1,0,0,1,0,1,1 each 434 cycles (50 MHz/115200).
REQ-034 P_UART_CHECK=1, drive RX frame 8'h3C with parity 1 -> o_user_rx_data=8'h3C valid; same with parity 0 -> o_rx_parity_err pulse, no valid.
REQ-035 Write 17 words back-to-back at depth 16 with TX idle line -> ready low after FIFO fills, all 17 transmitted in order with no inter-frame gap.
REQ-036 Hold i_user_rx_ready=0, send 17 good frames -> 16 stored, o_rx_overrun one pulse, first 16 read back in order.
REQ-037 RX low pulse of DIV/4 cycles -> no data, no error; stop bit forced 0 -> o_rx_frame_err pulse.
REQ-038 Assert i_rst_n low in mid-TX DATA state -> o_uart_tx=1 same cycle, FIFOs empty, next word sent cleanly after release.
